// File: rtl/booth_seq_mult_ctrl_if.sv
// Start/ready handshake and result bus between the system bus registers
// and the radix-4 Booth multiply sequencer.
interface booth_seq_mult_ctrl_if #(
    parameter int unsigned NUMBER_OF_BITS = 12
);
    logic                          start;
    logic [NUMBER_OF_BITS-1:0]     multiplicand;
    logic [NUMBER_OF_BITS-1:0]     multiplier;
    logic                          ready;
    logic                          busy;
    logic                          done;
    logic [2*NUMBER_OF_BITS-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output ready, busy, done, product
    );
endinterface

// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-4 Booth signed multiplier: one recoded digit per clock,
// exact 2N-bit product delivered with a one-cycle done pulse.
module booth_seq_mult_ctrl #(
    parameter int unsigned NUMBER_OF_BITS = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    booth_seq_mult_ctrl_if.slave  bus
);
    localparam int unsigned N      = NUMBER_OF_BITS;
    localparam int unsigned PW     = 2 * N;
    localparam int unsigned DIGITS = N / 2;
    localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [N:0]       mplier_q;
    logic [PW-1:0]    product_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic             accept_c;
    logic             step_c;
    logic             last_c;
    logic [PW-1:0]    mcand_x2_c;
    logic [PW-1:0]    addend_c;
    logic [PW-1:0]    acc_sum_c;

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept_c = 1'b1;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                step_c = 1'b1;
                if (cnt_q == CNT_W'(DIGITS - 1)) begin
                    last_c  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // mcand_q already carries the 4^i weight; mplier_q[2:0] is the current Booth triple
    always_comb begin
        mcand_x2_c = {mcand_q[PW-2:0], 1'b0};
        addend_c   = '0;
        case (mplier_q[2:0])
            3'b001, 3'b010: addend_c = mcand_q;
            3'b011:         addend_c = mcand_x2_c;
            3'b100:         addend_c = ~mcand_x2_c + PW'(1);
            3'b101, 3'b110: addend_c = ~mcand_q + PW'(1);
            default:        addend_c = '0;
        endcase
        acc_sum_c = acc_q + addend_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
        end else if (accept_c) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{N{bus.multiplicand[N-1]}}, bus.multiplicand};
            mplier_q <= {bus.multiplier, 1'b0};
        end else if (step_c) begin
            cnt_q    <= cnt_q + CNT_W'(1);
            acc_q    <= acc_sum_c;
            mcand_q  <= {mcand_q[PW-3:0], 2'b00};
            mplier_q <= {2'b00, mplier_q[N:2]};
            if (last_c) begin
                product_q <= acc_sum_c;
            end
        end
    end

    // Status flags follow the next state so they change on the same edge as state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d == S_CALC);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign bus.ready   = ready_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule
